// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto one backing memory port, with D-side starvation guard.
// Optional GRANT watchdog is compiled in with `define MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate between i_req and d_req each cycle
// S_GRANT | latched request driven on mem_*, waiting for mem_ack/timeout
// S_RESP  | owner's ready pulses for this single cycle, rdata is valid
module mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  busy,
  output logic                  owner,
  output logic                  err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  grant_d;
  logic                  grant_i;
  logic                  complete;
  logic                  timeout_hit;
  logic                  starve_ok;
  logic [SW-1:0]         starve_cnt;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            lat_be;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic [DATA_WIDTH-1:0] rdata_val;

  assign starve_ok = (starve_cnt < STARVE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req && (!i_req || starve_ok)) begin
          grant_d = 1'b1;
          state_d = S_GRANT;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (mem_ack || timeout_hit) begin
          complete = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A write or a watchdog expiry returns zero rather than whatever is on mem_rdata.
  assign rdata_val = (lat_we || timeout_hit) ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= 4'h0;
      owner_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_wdata <= d_wdata;
        lat_be    <= d_be;
        owner_q   <= 1'b1;
      end else if (grant_i) begin
        lat_addr  <= i_addr;
        lat_we    <= 1'b0;
        lat_wdata <= '0;
        lat_be    <= 4'hF;
        owner_q   <= 1'b0;
      end
      if (complete) begin
        if (owner_q) begin
          d_rdata_q <= rdata_val;
        end else begin
          i_rdata_q <= rdata_val;
        end
      end
    end
  end

  // Only D grants that actually make a pending fetch wait count toward starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // The counter always passes through IDLE before GRANT, so clearing there covers GRANT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state_q == S_IDLE) begin
      wd_cnt <= '0;
    end else if ((state_q == S_GRANT) && !mem_ack) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_GRANT) && (wd_cnt == WD_LAST) && !mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= complete && timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign mem_req   = (state_q == S_GRANT);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_be    = lat_be;

  assign busy    = (state_q != S_IDLE);
  assign owner   = owner_q;
  assign i_ready = (state_q == S_RESP) && !owner_q;
  assign d_ready = (state_q == S_RESP) &&  owner_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, write, contention order, reset abort, watchdog.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant_seen"}, 32'(mem_req), 32'd1);
  endtask

  // Waits for GRANT, checks the latched request, acks immediately, checks the RESP cycle.
  task automatic serve(input string tag, input logic exp_owner, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] rd);
    wait_grant(tag);
    chk({tag, "_owner"}, 32'(owner), 32'(exp_owner));
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
    if (exp_owner) begin
      chk({tag, "_d_ready"}, 32'(d_ready), 32'd1);
      chk({tag, "_d_rdata"}, d_rdata, rd);
    end else begin
      chk({tag, "_i_ready"}, 32'(i_ready), 32'd1);
      chk({tag, "_i_rdata"}, i_rdata, rd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int ready_seen;

    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'h0;
    mem_ack = 1'b0; mem_rdata = '0;

    // reset state
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_rdatas", i_rdata | d_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // single read with minimum latency; d_req held through RESP must not regrant
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF;
    tick();
    chk("rd_mem_req", 32'(mem_req), 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_owner", 32'(owner), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_no_early_ready", 32'(d_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("rd_d_ready", 32'(d_ready), 32'd1);
    chk("rd_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("rd_i_ready", 32'(i_ready), 32'd0);
    chk("rd_resp_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("rd_no_regrant", 32'(busy), 32'd0);
    chk("rd_ready_one_cycle", 32'(d_ready), 32'd0);
    d_req = 1'b0;
    tick();

    // stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_readys", {30'd0, i_ready, d_ready}, 32'd0);
    tick();
    chk("stray_d_rdata_held", d_rdata, 32'hDEADBEEF);
    chk("stray_i_rdata", i_rdata, 32'd0);

    // write; requester inputs changed during GRANT must not leak through
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h1234ABCD; d_addr = 32'h104;
    tick();
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_be", 32'(mem_be), 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'h1234ABCD);
    d_addr = 32'hBAD; d_wdata = 32'h0; d_we = 1'b0;
    tick();
    chk("wr_addr_latched", mem_addr, 32'h104);
    chk("wr_wdata_latched", mem_wdata, 32'h1234ABCD);
    chk("wr_we_latched", 32'(mem_we), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    chk("wr_d_ready", 32'(d_ready), 32'd1);
    chk("wr_d_rdata_zero", d_rdata, 32'd0);
    tick(); tick();

    // contention: D,D,D,D,I,D,D,D,D,I
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_be = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      serve($sformatf("arb%0d", k), exp_d[k], exp_d[k] ? 32'h300 : 32'h200,
            exp_d[k] ? 4'b0011 : 4'hF, 32'hC000_0000 + 32'(k));
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // reset two cycles into GRANT aborts with no ready pulse
    d_req = 1'b1; d_addr = 32'h400; d_be = 4'hF;
    tick();
    chk("rg_in_grant", 32'(mem_req), 32'd1);
    tick(); tick();
    d_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rg_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rg_busy", 32'(busy), 32'd0);
    chk("rg_owner", 32'(owner), 32'd0);
    chk("rg_d_rdata_clr", d_rdata, 32'd0);
    ready_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (i_ready || d_ready) ready_seen++;
    end
    chk("rg_no_ready", 32'(ready_seen), 32'd0);
    i_req = 1'b1; i_addr = 32'h500;
    rst = 1'b1;
    tick();
    chk("rg_first_arb", 32'(mem_req), 32'd1);
    chk("rg_i_owner", 32'(owner), 32'd0);
    chk("rg_i_addr", mem_addr, 32'h500);
    chk("rg_i_be", 32'(mem_be), 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    chk("rg_i_ready", 32'(i_ready), 32'd1);
    chk("rg_i_rdata", i_rdata, 32'hA5A5A5A5);
    tick(); tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog expiry 8 cycles after entering GRANT
    d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
    tick();
    d_req = 1'b0; mem_rdata = 32'h77777777;
    for (int j = 1; j < 8; j++) begin
      tick();
    end
    chk("to_still_grant", 32'(mem_req), 32'd1);
    chk("to_no_err_yet", 32'(err), 32'd0);
    tick();
    chk("to_d_ready", 32'(d_ready), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata_zero", d_rdata, 32'd0);
    tick();
    chk("to_err_clear", 32'(err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    // ack on the expiry cycle wins
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    for (int j = 1; j < 8; j++) begin
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    mem_ack = 1'b0;
    chk("toack_d_ready", 32'(d_ready), 32'd1);
    chk("toack_err", 32'(err), 32'd0);
    chk("toack_rdata", d_rdata, 32'h13579BDF);
    tick();
`else
    // without the watchdog GRANT waits for mem_ack indefinitely
    d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
    tick();
    d_req = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick();
    end
    chk("nto_still_grant", 32'(mem_req), 32'd1);
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_err", 32'(err), 32'd0);
    chk("nto_no_ready", 32'(d_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    mem_ack = 1'b0;
    chk("nto_d_ready", 32'(d_ready), 32'd1);
    chk("nto_rdata", d_rdata, 32'h13579BDF);
    chk("nto_err_done", 32'(err), 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
